uart_param: RTL and testbench
=============================

Name: uart_param

Overview:
- Parametrised full-duplex UART, successor to the fixed 8N1 uart.
- Configurable data width, parity, stop bits and oversampling.
- TX uses a valid/ready input handshake; RX uses a valid/ready output with error pulses.
- Sits between board-level i_rx/o_tx pins and user logic; generates its own baud tick, so no external clock_divider is needed.

Parameters:
- INPUT_CLOCK, 27000000: i_clk frequency in Hz.
- BAUD_RATE, 115200: line rate in bit/s.
- DATA_BITS, 8: payload width, legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2. TX sends this many stop bits; RX checks only the first.
- OVERSAMPLE, 16: ticks per bit. Must be an even number ≥ 4.
- FIFO_DEPTH, 4: RX FIFO entries, power of 2. Used only when UART_RX_FIFO_EN is defined.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous active-high reset.
- i_rx  in  1  asynchronous serial input. Idles high.
- o_tx  out  1  serial output. Idles high.
- i_tx_data  in  DATA_BITS  byte to transmit.
- i_tx_valid  in  1  i_tx_data is valid.
- o_tx_ready  out  1  transmitter can accept a word.
- o_rx_data  out  DATA_BITS  received word.
- o_rx_valid  out  1  o_rx_data is valid. Held until consumed.
- i_rx_ready  in  1  consumer accepts o_rx_data.
- o_rx_frame_err  out  1  one-cycle pulse: stop bit sampled low.
- o_rx_parity_err  out  1  one-cycle pulse: parity mismatch.
- o_rx_overrun  out  1  one-cycle pulse: word dropped because the RX store was full.

Behaviour:
- Reset values: o_tx = 1, o_tx_ready = 1, o_rx_valid = 0, o_rx_data = 0, all error pulses 0.
- Reset clears all state machines, counters, the synchroniser (to 1) and the FIFO.
- Reset asserted mid-frame abandons the frame. o_tx is high on the next edge.
- Baud tick: counter divisor DIV = (INPUT_CLOCK + BAUD_RATE*OVERSAMPLE/2) / (BAUD_RATE*OVERSAMPLE), integer-rounded, minimum 1. The tick is a one-cycle pulse every DIV clocks.
- Bit period = DIV*OVERSAMPLE clocks.
- TX handshake: a word transfers when i_tx_valid && o_tx_ready.
  - On the transfer edge, data is latched and o_tx_ready falls.
  - o_tx goes low on the same edge (start bit). Latency is 1 clock from the transfer cycle.
  - The TX tick phase restarts on transfer, so each bit lasts exactly one bit period.
- TX states: IDLE → START → DATA (DATA_BITS bits, LSB first) → PARITY (skipped if PARITY = 0) → STOP (STOP_BITS periods, o_tx = 1) → IDLE.
  - o_tx_ready rises on the edge that ends the last stop bit.
  - A valid word held on i_tx_valid is accepted in that same cycle, giving back-to-back frames with no idle gap.
- Parity bit: odd = ~^data, even = ^data.
- RX front end: i_rx passes through a 2-flop synchroniser (2 clocks latency).
- RX states:
  - IDLE: waits for the synchronised line to be low; the tick phase restarts.
  - START: after OVERSAMPLE/2 ticks, resample. If high, this is a glitch: return to IDLE and report no error.
  - DATA: sample every OVERSAMPLE ticks, at mid-bit. Shift in LSB first.
  - PARITY: sample and compare (state skipped if PARITY = 0).
  - STOP: sample the first stop bit.
- RX result, decided at the mid-stop sample:
  - Stop low: pulse o_rx_frame_err and discard the word.
  - Parity bad: pulse o_rx_parity_err and discard the word.
  - Otherwise: store the word.
  - In all three cases, return to IDLE immediately at mid-stop, so the next start edge can be detected inside the stop bit.
- RX store, no FIFO: a single holding register.
  - o_rx_valid is set on store and cleared on the i_rx_ready edge.
  - If a store and a consume happen in the same cycle, the new word loads and o_rx_valid stays 1.
  - Store while valid and not consumed: pulse o_rx_overrun, new word dropped, old word kept.
- Error pulses are exactly 1 clock wide. Frame error takes priority over parity error; only one is pulsed per frame.

Optional Feature:
- Macro: UART_RX_FIFO_EN.
- Defined: the RX store is a FIFO_DEPTH-entry FIFO.
  - o_rx_valid = not empty. o_rx_data = head entry, first-word-fall-through.
  - Simultaneous push and pop when full succeeds with no overrun.
  - Push when full without a pop: o_rx_overrun pulses and the new word is dropped.
- Undefined: the single holding register described above. FIFO_DEPTH is ignored.

Test Plan (INPUT_CLOCK = 3200000, BAUD_RATE = 100000, OVERSAMPLE = 16, so DIV = 2 and the bit period is 32 clocks):
- 8N1 TX: i_tx_data = 0x5A with valid for 1 cycle → o_tx reads 0,0,1,0,1,1,0,1,0,1, each level 32 clocks. o_tx_ready is low for 320 clocks and the start bit begins 1 clock after transfer.
- 8N1 RX loopback with i_rx = o_tx: send 0x00, 0xFF, 0xA5 back-to-back with i_rx_ready = 1 → o_rx_valid fires 3 times with data 0x00, 0xFF, 0xA5. No error pulses.
- PARITY = 2, DATA_BITS = 7, STOP_BITS = 2, send 0x41 → TX parity bit 0, line high for 64 clocks after parity. Injecting a flipped parity bit on RX → o_rx_parity_err pulses once and o_rx_valid stays 0.
- RX framing and glitch: drive stop bit low for 0x33 → o_rx_frame_err pulse, no valid. Drive a 6-clock low glitch on idle i_rx → no state change and no pulses.
- Overrun: i_rx_ready = 0, receive 2 words (no FIFO) → first word held, o_rx_overrun pulses at the second mid-stop. With UART_RX_FIFO_EN and FIFO_DEPTH = 4, 5 words → 4 held in order, overrun on the 5th.
- Reset mid-TX: assert i_rst during data bit 3 of 0xC3 → o_tx = 1 and o_tx_ready = 1 the next edge. A new word sent after reset transmits correctly.

Source files
------------

// File: rtl/uart_param.sv
`timescale 1ns/1ps
// uart_param: parametrised full-duplex UART with internal baud timing.
// Define UART_RX_FIFO_EN to replace the RX holding register with a FIFO_DEPTH-entry FIFO.
module uart_param #(
  parameter int INPUT_CLOCK = 27000000,
  parameter int BAUD_RATE   = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  output logic                 o_tx,
  input  logic [DATA_BITS-1:0] i_tx_data,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  input  logic                 i_rx_ready,
  output logic                 o_rx_frame_err,
  output logic                 o_rx_parity_err,
  output logic                 o_rx_overrun
);

  // state    | meaning
  // S_IDLE   | line idle; TX accepts a word, RX hunts for a falling edge
  // S_START  | start bit (RX: waiting for the mid-start glitch check)
  // S_DATA   | payload bits, LSB first
  // S_PARITY | parity bit (never entered when PARITY = 0)
  // S_STOP   | stop bit(s); RX decides the frame at mid-stop
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  localparam int DIV_RAW   = (INPUT_CLOCK + BAUD_RATE * OVERSAMPLE / 2) / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV       = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int BIT_CLKS  = DIV * OVERSAMPLE;
  localparam int HALF_CLKS = DIV * (OVERSAMPLE / 2);
  localparam int CW        = $clog2(BIT_CLKS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CLKS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_bits
    $error("uart_param: DATA_BITS must be 5..9");
  end
  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_chk_os
    $error("uart_param: OVERSAMPLE must be even and >= 4");
  end
  if (FIFO_DEPTH < 1) begin : g_chk_depth
    $error("uart_param: FIFO_DEPTH must be >= 1");
  end

  // Bit timing counts clocks directly: DIV clocks per tick, OVERSAMPLE ticks per bit.
  state_e                tx_state_q, tx_state_d;
  logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
  logic [3:0]            tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0]  tx_shift_q, tx_shift_d;
  logic                  tx_par_q, tx_par_d;
  logic                  tx_q, tx_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    if (tx_state_q != S_IDLE) tx_cnt_d = (tx_cnt_q == '0) ? BIT_LAST : tx_cnt_q - CW'(1);
    case (tx_state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (i_tx_valid) begin
          tx_shift_d = i_tx_data;
          tx_par_d   = (PARITY == 1) ? ~^i_tx_data : ^i_tx_data;
          tx_cnt_d   = BIT_LAST;
          tx_d       = 1'b0;
          tx_state_d = S_START;
        end
      end
      S_START: if (tx_cnt_q == '0) begin
        tx_d       = tx_shift_q[0];
        tx_shift_d = tx_shift_q >> 1;
        tx_bit_d   = '0;
        tx_state_d = S_DATA;
      end
      S_DATA: if (tx_cnt_q == '0) begin
        if (tx_bit_q == 4'(DATA_BITS - 1)) begin
          tx_bit_d   = '0;
          tx_d       = (PARITY != 0) ? tx_par_q : 1'b1;
          tx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
        end else begin
          tx_bit_d   = tx_bit_q + 4'd1;
          tx_d       = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
        end
      end
      S_PARITY: if (tx_cnt_q == '0) begin
        tx_d       = 1'b1;
        tx_state_d = S_STOP;
      end
      S_STOP: if (tx_cnt_q == '0) begin
        tx_d = 1'b1;
        if (tx_bit_q == 4'(STOP_BITS - 1)) tx_state_d = S_IDLE;
        else tx_bit_d = tx_bit_q + 4'd1;
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  assign o_tx       = tx_q;
  assign o_tx_ready = (tx_state_q == S_IDLE);

  state_e                rx_state_q, rx_state_d;
  logic [CW-1:0]         rx_cnt_q, rx_cnt_d;
  logic [3:0]            rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0]  rx_shift_q, rx_shift_d;
  logic                  rx_par_ok_q, rx_par_ok_d;
  logic                  rx_s1_q, rx_s2_q;
  logic                  frame_err_q, frame_err_d, parity_err_q, parity_err_d;
  logic                  overrun_q, overrun_d;
  logic                  push;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_state_q   <= S_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_par_ok_q  <= 1'b1;
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_par_ok_q  <= rx_par_ok_d;
      rx_s1_q      <= i_rx;
      rx_s2_q      <= rx_s1_q;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_par_ok_d  = rx_par_ok_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    push         = 1'b0;
    if (rx_state_q != S_IDLE) rx_cnt_d = (rx_cnt_q == '0) ? BIT_LAST : rx_cnt_q - CW'(1);
    case (rx_state_q)
      S_IDLE: if (!rx_s2_q) begin
        rx_cnt_d    = HALF_LAST;
        rx_par_ok_d = 1'b1;
        rx_state_d  = S_START;
      end
      S_START: if (rx_cnt_q == '0) begin
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_cnt_q == '0) begin
        rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
        rx_bit_d   = rx_bit_q + 4'd1;
        if (rx_bit_q == 4'(DATA_BITS - 1)) rx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: if (rx_cnt_q == '0) begin
        rx_par_ok_d = (rx_s2_q == ((PARITY == 1) ? ~^rx_shift_q : ^rx_shift_q));
        rx_state_d  = S_STOP;
      end
      S_STOP: if (rx_cnt_q == '0) begin
        // Leave at mid-stop so a start edge inside the stop bit is still caught.
        rx_state_d = S_IDLE;
        if (!rx_s2_q) frame_err_d = 1'b1;
        else if (!rx_par_ok_q) parity_err_d = 1'b1;
        else push = 1'b1;
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

`ifdef UART_RX_FIFO_EN
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_q, rd_q;
  logic [AW:0]          cnt_q;
  logic                 pop, full, do_push;

  assign pop       = (cnt_q != '0) && i_rx_ready;
  assign full      = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign do_push   = push && (!full || pop);
  assign overrun_d = push && full && !pop;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= rx_shift_q;
        wr_q        <= (wr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_q + AW'(1);
      end
      if (pop) rd_q <= (rd_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_q + AW'(1);
      if (do_push && !pop) cnt_q <= cnt_q + (AW+1)'(1);
      else if (!do_push && pop) cnt_q <= cnt_q - (AW+1)'(1);
    end
  end

  assign o_rx_valid = (cnt_q != '0);
  assign o_rx_data  = mem_q[rd_q];
`else
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 valid_q, valid_d;
  logic                 consume;

  assign consume = valid_q && i_rx_ready;

  always_comb begin
    hold_d    = hold_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (consume) valid_d = 1'b0;
    if (push) begin
      if (!valid_q || consume) begin
        hold_d  = rx_shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      valid_q <= valid_d;
    end
  end

  assign o_rx_valid = valid_q;
  assign o_rx_data  = hold_q;
`endif

  assign o_rx_frame_err  = frame_err_q;
  assign o_rx_parity_err = parity_err_q;
  assign o_rx_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_param.sv
`timescale 1ns/1ps
// Bench for uart_param: an 8N1 instance (loopback capable) and a 7E2 instance.
module tb_uart_param;
  localparam int CLK_HZ = 3200000;
  localparam int BAUD   = 100000;
  localparam int OS     = 16;
  localparam int BITC   = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, loop_a, rx_drv_a, rx_drv_b, rx_a;
  logic [7:0] txd_a, rxd_a;
  logic [6:0] txd_b, rxd_b;
  logic txv_a, tx_a, txr_a, rxv_a, rxr_a, fe_a, pe_a, ov_a;
  logic txv_b, tx_b, txr_b, rxv_b, rxr_b, fe_b, pe_b, ov_b;

  assign rx_a = loop_a ? tx_a : rx_drv_a;

  uart_param #(.INPUT_CLOCK(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0),
               .STOP_BITS(1), .OVERSAMPLE(OS), .FIFO_DEPTH(4)) dut_a (
    .i_clk(clk), .i_rst(rst_a), .i_rx(rx_a), .o_tx(tx_a),
    .i_tx_data(txd_a), .i_tx_valid(txv_a), .o_tx_ready(txr_a),
    .o_rx_data(rxd_a), .o_rx_valid(rxv_a), .i_rx_ready(rxr_a),
    .o_rx_frame_err(fe_a), .o_rx_parity_err(pe_a), .o_rx_overrun(ov_a));

  uart_param #(.INPUT_CLOCK(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(2),
               .STOP_BITS(2), .OVERSAMPLE(OS), .FIFO_DEPTH(4)) dut_b (
    .i_clk(clk), .i_rst(rst_b), .i_rx(rx_drv_b), .o_tx(tx_b),
    .i_tx_data(txd_b), .i_tx_valid(txv_b), .o_tx_ready(txr_b),
    .o_rx_data(rxd_b), .o_rx_valid(rxv_b), .i_rx_ready(rxr_b),
    .o_rx_frame_err(fe_b), .o_rx_parity_err(pe_b), .o_rx_overrun(ov_b));

  int n_checks = 0;
  int n_pass   = 0;
  logic [8:0] sb[$];

  int fe_cnt_a = 0, pe_cnt_a = 0, ov_cnt_a = 0, vcnt_a = 0;
  int fe_cnt_b = 0, pe_cnt_b = 0, vcyc_b = 0;
  always @(negedge clk) begin
    fe_cnt_a += int'(fe_a);
    pe_cnt_a += int'(pe_a);
    ov_cnt_a += int'(ov_a);
    vcnt_a   += int'(rxv_a && rxr_a);
    fe_cnt_b += int'(fe_b);
    pe_cnt_b += int'(pe_b);
    vcyc_b   += int'(rxv_b);
  end

  function automatic logic [15:0] mk_frame(input logic [8:0] d, input int nb, input int par,
                                           input bit flip, input int nstop, input bit stop_low);
    logic [15:0] f;
    int k;
    logic p;
    f = '1; f[0] = 1'b0; k = 1; p = 1'b0;
    for (int i = 0; i < nb; i++) begin
      f[k[3:0]] = d[i[3:0]];
      p = p ^ d[i[3:0]];
      k++;
    end
    if (par != 0) begin
      f[k[3:0]] = ((par == 1) ? ~p : p) ^ flip;
      k++;
    end
    for (int s = 0; s < nstop; s++) begin
      f[k[3:0]] = (s == 0) ? ~stop_low : 1'b1;
      k++;
    end
    return f;
  endfunction

  task automatic send_tx(input int which, input logic [8:0] d);
    int t;
    t = 0;
    @(negedge clk);
    while (((which == 0) ? txr_a : txr_b) !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      n_checks++;
      $display("FAIL send_ready_timeout: o_tx_ready stayed low %0d cycles, required 1", t);
    end
    if (which == 0) begin txd_a = d[7:0]; txv_a = 1'b1; end
    else begin txd_b = d[6:0]; txv_b = 1'b1; end
    @(negedge clk);
    txv_a = 1'b0;
    txv_b = 1'b0;
  endtask

  task automatic capture_tx(input int which, input logic [15:0] lvls, input int n,
                            output int mism, output int rdy_low, output int hi_tail);
    logic line, rdy;
    logic [15:0] sh;
    mism = 0; rdy_low = 0; hi_tail = 0;
    for (int i = 0; i < n * BITC; i++) begin
      line = (which == 0) ? tx_a : tx_b;
      rdy  = (which == 0) ? txr_a : txr_b;
      sh   = lvls >> (i / BITC);
      if (line !== sh[0]) mism++;
      if (rdy === 1'b0) rdy_low++;
      if (i >= (n - 2) * BITC && line === 1'b1) hi_tail++;
      @(negedge clk);
    end
  endtask

  task automatic drive_line(input int which, input logic [15:0] lvls, input int n, input int last_len);
    logic [15:0] sh;
    sh = lvls;
    for (int b = 0; b < n; b++) begin
      if (which == 0) rx_drv_a = sh[0]; else rx_drv_b = sh[0];
      sh = sh >> 1;
      repeat ((b == n - 1) ? last_len : BITC) @(negedge clk);
    end
    if (which == 0) rx_drv_a = 1'b1; else rx_drv_b = 1'b1;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; loop_a = 1'b0;
    rx_drv_a = 1'b1; rx_drv_b = 1'b1;
    txd_a = '0; txd_b = '0; txv_a = 1'b0; txv_b = 1'b0;
    rxr_a = 1'b1; rxr_b = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (tx_a !== 1'b1) $display("FAIL reset_tx: got %b required 1", tx_a); else n_pass++;
    n_checks++; if (txr_a !== 1'b1) $display("FAIL reset_ready: got %b required 1", txr_a); else n_pass++;
    n_checks++; if (rxv_a !== 1'b0) $display("FAIL reset_valid: got %b required 0", rxv_a); else n_pass++;
    n_checks++; if (rxd_a !== 8'h00) $display("FAIL reset_data: got %h required 00", rxd_a); else n_pass++;
    n_checks++;
    if ({fe_a, pe_a, ov_a} !== 3'b000) $display("FAIL reset_errs: got %b required 000", {fe_a, pe_a, ov_a});
    else n_pass++;
    n_checks++; if (tx_b !== 1'b1) $display("FAIL reset_tx_b: got %b required 1", tx_b); else n_pass++;
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_tx_8n1();
    int mism, rl, ht;
    n_checks++; if (tx_a !== 1'b1) $display("FAIL tx_idle_before: got %b required 1", tx_a); else n_pass++;
    send_tx(0, 9'h05A);
    capture_tx(0, mk_frame(9'h05A, 8, 0, 1'b0, 1, 1'b0), 10, mism, rl, ht);
    n_checks++; if (mism !== 0) $display("FAIL tx_5a_line: got %0d wrong samples required 0", mism); else n_pass++;
    n_checks++; if (rl !== 320) $display("FAIL tx_5a_ready_low: got %0d clocks required 320", rl); else n_pass++;
    n_checks++; if (txr_a !== 1'b1) $display("FAIL tx_5a_ready_after: got %b required 1", txr_a); else n_pass++;
  endtask

  task automatic test_loopback();
    int got, t, fe0, pe0, ov0;
    logic [8:0] exp;
    loop_a = 1'b1; rxr_a = 1'b1;
    fe0 = fe_cnt_a; pe0 = pe_cnt_a; ov0 = ov_cnt_a;
    got = 0; t = 0;
    fork
      begin
        sb.push_back(9'h000); send_tx(0, 9'h000);
        sb.push_back(9'h0FF); send_tx(0, 9'h0FF);
        sb.push_back(9'h0A5); send_tx(0, 9'h0A5);
      end
      begin
        while (got < 3 && t < 3000) begin
          @(negedge clk);
          t++;
          if (rxv_a && rxr_a) begin
            got++;
            n_checks++;
            if (sb.size() == 0) $display("FAIL loop_unexpected: got word %h required none", rxd_a);
            else begin
              exp = sb.pop_front();
              if (rxd_a !== exp[7:0]) $display("FAIL loop_data: got %h required %h", rxd_a, exp[7:0]);
              else n_pass++;
            end
          end
        end
      end
    join
    n_checks++; if (got !== 3) $display("FAIL loop_count: got %0d words required 3", got); else n_pass++;
    repeat (40) @(negedge clk);
    n_checks++;
    if ((fe_cnt_a - fe0) + (pe_cnt_a - pe0) + (ov_cnt_a - ov0) !== 0)
      $display("FAIL loop_errs: got %0d pulses required 0", (fe_cnt_a - fe0) + (pe_cnt_a - pe0) + (ov_cnt_a - ov0));
    else n_pass++;
    loop_a = 1'b0;
  endtask

  task automatic test_parity();
    int mism, rl, ht, pe0, fe0, v0;
    logic [8:0] exp;
    send_tx(1, 9'h041);
    capture_tx(1, mk_frame(9'h041, 7, 2, 1'b0, 2, 1'b0), 11, mism, rl, ht);
    n_checks++; if (mism !== 0) $display("FAIL par_tx_line: got %0d wrong samples required 0", mism); else n_pass++;
    n_checks++; if (ht !== 64) $display("FAIL par_tx_stop_high: got %0d clocks required 64", ht); else n_pass++;
    n_checks++; if (rl !== 352) $display("FAIL par_tx_ready_low: got %0d clocks required 352", rl); else n_pass++;
    rxr_b = 1'b0;
    pe0 = pe_cnt_b; fe0 = fe_cnt_b; v0 = vcyc_b;
    drive_line(1, mk_frame(9'h041, 7, 2, 1'b1, 2, 1'b0), 11, BITC);
    repeat (64) @(negedge clk);
    n_checks++; if (pe_cnt_b - pe0 !== 1) $display("FAIL par_err_pulse: got %0d required 1", pe_cnt_b - pe0); else n_pass++;
    n_checks++; if (fe_cnt_b - fe0 !== 0) $display("FAIL par_no_frame_err: got %0d required 0", fe_cnt_b - fe0); else n_pass++;
    n_checks++; if (vcyc_b - v0 !== 0) $display("FAIL par_no_valid: got %0d valid cycles required 0", vcyc_b - v0); else n_pass++;
    sb.push_back(9'h041);
    drive_line(1, mk_frame(9'h041, 7, 2, 1'b0, 2, 1'b0), 11, BITC);
    repeat (16) @(negedge clk);
    exp = sb.pop_front();
    n_checks++;
    if (rxv_b !== 1'b1 || rxd_b !== exp[6:0])
      $display("FAIL par_good_rx: got valid %b data %h required valid 1 data %h", rxv_b, rxd_b, exp[6:0]);
    else n_pass++;
    rxr_b = 1'b1; @(negedge clk); rxr_b = 1'b0;
    n_checks++; if (rxv_b !== 1'b0) $display("FAIL par_consume: got valid %b required 0", rxv_b); else n_pass++;
  endtask

  task automatic test_frame_glitch();
    int fe0, pe0, v0, ov0;
    logic [8:0] exp;
    rxr_a = 1'b1;
    fe0 = fe_cnt_a; pe0 = pe_cnt_a; v0 = vcnt_a;
    drive_line(0, mk_frame(9'h033, 8, 0, 1'b0, 1, 1'b1), 10, 20);
    repeat (64) @(negedge clk);
    n_checks++; if (fe_cnt_a - fe0 !== 1) $display("FAIL frame_err_pulse: got %0d required 1", fe_cnt_a - fe0); else n_pass++;
    n_checks++; if (pe_cnt_a - pe0 !== 0) $display("FAIL frame_no_par: got %0d required 0", pe_cnt_a - pe0); else n_pass++;
    n_checks++; if (vcnt_a - v0 !== 0) $display("FAIL frame_no_valid: got %0d required 0", vcnt_a - v0); else n_pass++;
    fe0 = fe_cnt_a; pe0 = pe_cnt_a; v0 = vcnt_a; ov0 = ov_cnt_a;
    rx_drv_a = 1'b0;
    repeat (6) @(negedge clk);
    rx_drv_a = 1'b1;
    repeat (64) @(negedge clk);
    n_checks++;
    if ((fe_cnt_a - fe0) + (pe_cnt_a - pe0) + (ov_cnt_a - ov0) + (vcnt_a - v0) !== 0)
      $display("FAIL glitch_quiet: got %0d events required 0",
               (fe_cnt_a - fe0) + (pe_cnt_a - pe0) + (ov_cnt_a - ov0) + (vcnt_a - v0));
    else n_pass++;
    rxr_a = 1'b0;
    sb.push_back(9'h033);
    drive_line(0, mk_frame(9'h033, 8, 0, 1'b0, 1, 1'b0), 10, BITC);
    repeat (16) @(negedge clk);
    exp = sb.pop_front();
    n_checks++;
    if (rxv_a !== 1'b1 || rxd_a !== exp[7:0])
      $display("FAIL glitch_then_rx: got valid %b data %h required valid 1 data %h", rxv_a, rxd_a, exp[7:0]);
    else n_pass++;
    rxr_a = 1'b1; @(negedge clk); rxr_a = 1'b0;
  endtask

  task automatic test_overrun();
    int ov0, nw;
    logic [7:0] wv [5];
    logic [8:0] exp;
    wv = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    rxr_a = 1'b0;
    ov0 = ov_cnt_a;
`ifdef UART_RX_FIFO_EN
    nw = 5;
`else
    nw = 2;
`endif
    for (int i = 0; i < nw - 1; i++) sb.push_back({1'b0, wv[i]});
    for (int i = 0; i < nw; i++) drive_line(0, mk_frame({1'b0, wv[i]}, 8, 0, 1'b0, 1, 1'b0), 10, BITC);
    repeat (32) @(negedge clk);
    n_checks++; if (ov_cnt_a - ov0 !== 1) $display("FAIL overrun_pulse: got %0d required 1", ov_cnt_a - ov0); else n_pass++;
    while (sb.size() != 0) begin
      exp = sb.pop_front();
      n_checks++;
      if (rxv_a !== 1'b1 || rxd_a !== exp[7:0])
        $display("FAIL overrun_held: got valid %b data %h required valid 1 data %h", rxv_a, rxd_a, exp[7:0]);
      else n_pass++;
      rxr_a = 1'b1; @(negedge clk); rxr_a = 1'b0;
    end
    n_checks++; if (rxv_a !== 1'b0) $display("FAIL overrun_drained: got valid %b required 0", rxv_a); else n_pass++;
  endtask

  task automatic test_reset_mid_tx();
    int mism, rl, ht;
    logic [7:0] c3;
    c3 = 8'hC3;
    send_tx(0, 9'h0C3);
    repeat (140) @(negedge clk);
    n_checks++; if (tx_a !== c3[3]) $display("FAIL rst_bit3_line: got %b required %b", tx_a, c3[3]); else n_pass++;
    rst_a = 1'b1;
    @(negedge clk);
    n_checks++; if (tx_a !== 1'b1) $display("FAIL rst_mid_tx: got %b required 1", tx_a); else n_pass++;
    n_checks++; if (txr_a !== 1'b1) $display("FAIL rst_mid_ready: got %b required 1", txr_a); else n_pass++;
    rst_a = 1'b0;
    send_tx(0, 9'h096);
    capture_tx(0, mk_frame(9'h096, 8, 0, 1'b0, 1, 1'b0), 10, mism, rl, ht);
    n_checks++; if (mism !== 0) $display("FAIL rst_after_line: got %0d wrong samples required 0", mism); else n_pass++;
    n_checks++; if (rl !== 320) $display("FAIL rst_after_ready_low: got %0d clocks required 320", rl); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_tx_8n1();
    test_loopback();
    test_parity();
    test_frame_glitch();
    test_overrun();
    test_reset_mid_tx();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded 2 ms, required completion");
    $fatal(1, "watchdog");
  end

endmodule
